// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit MIPS core: byte-wise fetch, decode,
// then execute/memory/writeback sequencing for lb, sb, R-type, beq, j, addi.
module mips_controller #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LB    = 6'b100000,
  parameter logic [5:0] OP_SB    = 6'b101000,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       memtoreg,
  output logic       iord,
  output logic       regdst,
  output logic [1:0] pcsrc,
  output logic [3:0] irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       memwrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  state_t     state_q, state_d;
  logic       pcwrite, branch;
  logic [3:0] irwrite_raw;
  logic       regwrite_raw, memwrite_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = FETCH1;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    alucontrol   = 3'b000;
    memtoreg     = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    pcsrc        = 2'b00;
    irwrite_raw  = 4'b0000;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    case (state_q)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        // Each fetch step latches one instruction byte and bumps PC by one.
        irwrite_raw = 4'b0001 << state_q[1:0];
        alusrcb     = 2'b01;
        alucontrol  = 3'b010;
        pcwrite     = 1'b1;
        state_d     = (state_q == FETCH4) ? DECODE : state_t'(state_q + 4'd1);
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
        if (op == OP_LB || op == OP_SB) state_d = MEMADR;
        else if (op == OP_RTYPE)        state_d = RTYPEEX;
        else if (op == OP_BEQ)          state_d = BEQEX;
        else if (op == OP_J)            state_d = JEX;
        else if (op == OP_ADDI)         state_d = ADDIEX;
        else                            state_d = FETCH1;
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        state_d    = (op == OP_LB) ? LBRD : SBWR;
      end
      LBRD: begin
        iord    = 1'b1;
        state_d = LBWR;
      end
      LBWR: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      SBWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
        state_d = RTYPEWR;
      end
      RTYPEWR: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        branch     = 1'b1;
        pcsrc      = 2'b01;
      end
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        state_d    = ADDIWR;
      end
      ADDIWR: regwrite_raw = 1'b1;
      default: state_d = FETCH1;
    endcase
  end

  // Architectural write enables are held off while reset is asserted.
  assign pcen     = reset & (pcwrite | (branch & zero));
  assign irwrite  = reset ? irwrite_raw : 4'b0000;
  assign regwrite = reset & regwrite_raw;
  assign memwrite = reset & memwrite_raw;
  assign state    = state_q;

endmodule

// File: tb/tb_mips_controller.sv
// Directed table-driven bench for mips_controller: per-cycle expected state and
// control word, plus a hand-written asynchronous reset sequence in ADDIEX.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       alusrca, memtoreg, iord, regdst, pcen, regwrite, memwrite;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] irwrite, state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;

  vec_t vecs[$];

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .memtoreg(memtoreg), .iord(iord), .regdst(regdst), .pcsrc(pcsrc),
    .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite), .memwrite(memwrite),
    .state(state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Control word: {alusrca, alusrcb, alucontrol, memtoreg, iord, regdst, pcsrc, irwrite, pcen, regwrite, memwrite}
  function automatic logic [17:0] c(logic a, logic [1:0] b, logic [2:0] alu, logic m2r,
                                    logic io, logic rd, logic [1:0] ps, logic [3:0] ir,
                                    logic pe, logic rw, logic mw);
    return {a, b, alu, m2r, io, rd, ps, ir, pe, rw, mw};
  endfunction

  // Driver tasks that build the vector table
  task automatic push(input logic [5:0] o, input logic [5:0] f, input logic z,
                      input logic [3:0] st, input logic [17:0] ctl);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic push_fetch_decode(input logic [5:0] o, input logic [5:0] f, input logic z);
    push(o, f, z, 4'd0, c(0, 2'b01, 3'b010, 0, 0, 0, 2'b00, 4'b0001, 1, 0, 0));
    push(o, f, z, 4'd1, c(0, 2'b01, 3'b010, 0, 0, 0, 2'b00, 4'b0010, 1, 0, 0));
    push(o, f, z, 4'd2, c(0, 2'b01, 3'b010, 0, 0, 0, 2'b00, 4'b0100, 1, 0, 0));
    push(o, f, z, 4'd3, c(0, 2'b01, 3'b010, 0, 0, 0, 2'b00, 4'b1000, 1, 0, 0));
    push(o, f, z, 4'd4, c(0, 2'b11, 3'b010, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0));
  endtask

  task automatic push_rtype(input logic [5:0] f, input logic [2:0] alu, input logic z);
    push_fetch_decode(6'b000000, f, z);
    push(6'b000000, f, z, 4'd9,  c(1, 2'b00, alu,    0, 0, 0, 2'b00, 4'b0000, 0, 0, 0));
    push(6'b000000, f, z, 4'd10, c(0, 2'b00, 3'b000, 0, 0, 1, 2'b00, 4'b0000, 0, 1, 0));
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [3:0] exp_st, input logic [17:0] exp_ctl);
    logic [21:0] act, exp;
    act = {state, alusrca, alusrcb, alucontrol, memtoreg, iord, regdst, pcsrc,
           irwrite, pcen, regwrite, memwrite};
    exp = {exp_st, exp_ctl};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
               name, act[21:18], act[17:0], exp[21:18], exp[17:0]);
    end
  endtask

  localparam logic [17:0] RST_CTL = 18'b0_01_010_0_0_0_00_0000_0_0_0;

  initial begin
    reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0;

    // R-type: sub, add, and, or, slt, unknown funct
    push_rtype(6'b100010, 3'b110, 1'b0);
    push_rtype(6'b100000, 3'b010, 1'b1);
    push_rtype(6'b100100, 3'b000, 1'b0);
    push_rtype(6'b100101, 3'b001, 1'b1);
    push_rtype(6'b101010, 3'b111, 1'b0);
    push_rtype(6'b000111, 3'b010, 1'b0);
    // lb with zero held high: pcen must not leak outside fetch
    push_fetch_decode(6'b100000, 6'd0, 1'b1);
    push(6'b100000, 6'd0, 1'b1, 4'd5, c(1, 2'b10, 3'b010, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0));
    push(6'b100000, 6'd0, 1'b1, 4'd6, c(0, 2'b00, 3'b000, 0, 1, 0, 2'b00, 4'b0000, 0, 0, 0));
    push(6'b100000, 6'd0, 1'b1, 4'd7, c(0, 2'b00, 3'b000, 1, 0, 0, 2'b00, 4'b0000, 0, 1, 0));
    // beq taken, then not taken
    push_fetch_decode(6'b000100, 6'd0, 1'b1);
    push(6'b000100, 6'd0, 1'b1, 4'd11, c(1, 2'b00, 3'b110, 0, 0, 0, 2'b01, 4'b0000, 1, 0, 0));
    push_fetch_decode(6'b000100, 6'd0, 1'b0);
    push(6'b000100, 6'd0, 1'b0, 4'd11, c(1, 2'b00, 3'b110, 0, 0, 0, 2'b01, 4'b0000, 0, 0, 0));
    // sb
    push_fetch_decode(6'b101000, 6'd0, 1'b1);
    push(6'b101000, 6'd0, 1'b1, 4'd5, c(1, 2'b10, 3'b010, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0));
    push(6'b101000, 6'd0, 1'b1, 4'd8, c(0, 2'b00, 3'b000, 0, 1, 0, 2'b00, 4'b0000, 0, 0, 1));
    // illegal op: DECODE straight back to FETCH1
    push_fetch_decode(6'b111111, 6'd0, 1'b1);
    // j
    push_fetch_decode(6'b000010, 6'd0, 1'b0);
    push(6'b000010, 6'd0, 1'b0, 4'd12, c(0, 2'b00, 3'b000, 0, 0, 0, 2'b10, 4'b0000, 1, 0, 0));
    // addi
    push_fetch_decode(6'b001000, 6'd0, 1'b1);
    push(6'b001000, 6'd0, 1'b1, 4'd13, c(1, 2'b10, 3'b010, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0));
    push(6'b001000, 6'd0, 1'b1, 4'd14, c(0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 4'b0000, 0, 1, 0));

    // Reset held for two cycles
    repeat (2) begin
      @(negedge clk);
      check("in_reset", 4'd0, RST_CTL);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
      @(negedge clk);
      check($sformatf("vec%0d_st%0d", i, vecs[i].st), vecs[i].st, vecs[i].ctl);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of an addi (state 13)
    op = 6'b001000; funct = 6'd0; zero = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("addiex_before_rst", 4'd13, c(1, 2'b10, 3'b010, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0));
    #1 reset = 1'b0;
    #1 check("async_rst_immediate", 4'd0, RST_CTL);
    @(negedge clk);
    check("async_rst_hold1", 4'd0, RST_CTL);
    @(posedge clk); @(negedge clk);
    check("async_rst_hold2", 4'd0, RST_CTL);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("restart_fetch1", 4'd0, c(0, 2'b01, 3'b010, 0, 0, 0, 2'b00, 4'b0001, 1, 0, 0));
    @(posedge clk); @(negedge clk);
    check("restart_fetch2", 4'd1, c(0, 2'b01, 3'b010, 0, 0, 0, 2'b00, 4'b0010, 1, 0, 0));

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
